// File: rtl/eight_bit_down_timer_if.sv
// Control/status bundle for the eight-bit down timer.
// Master drives switches and buttons, slave returns count and status.
interface eight_bit_down_timer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_value;
  logic             preset_btn;
  logic             start_btn;
  logic             pause_btn;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;

  modport master (
    output load_value,
    output preset_btn,
    output start_btn,
    output pause_btn,
    input  count,
    input  running,
    input  done
  );

  modport slave (
    input  load_value,
    input  preset_btn,
    input  start_btn,
    input  pause_btn,
    output count,
    output running,
    output done
  );
endinterface

// File: rtl/eight_bit_down_timer.sv
// Prescaled 8-bit countdown timer with start, pause/resume,
// level preset and a sticky done flag.
module eight_bit_down_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset_btn,
  eight_bit_down_timer_if.slave tmr
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             start_prev_q, start_prev_d;
  logic             pause_prev_q, pause_prev_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic start_edge;
  logic pause_edge;
  logic tick;
  logic is_zero;
  logic at_one;

  assign start_edge = tmr.start_btn & ~start_prev_q;
  assign pause_edge = tmr.pause_btn & ~pause_prev_q;
  assign tick       = (state_q == S_RUN) && (presc_q == P_LAST);
  assign is_zero    = (count_q == '0);
  assign at_one     = (count_q == WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    presc_d      = presc_q;
    start_prev_d = tmr.start_btn;
    pause_prev_d = tmr.pause_btn;
    if (tmr.preset_btn) begin
      count_d = tmr.load_value;
      state_d = S_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            if (is_zero) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
              presc_d = '0;
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            presc_d = '0;
            if (!is_zero) count_d = count_q - 1'b1;
            // reaching zero outranks a coincident pause
            if (at_one || is_zero) state_d = S_DONE;
            else if (pause_edge) state_d = S_PAUSE;
          end else begin
            presc_d = presc_q + 1'b1;
            if (pause_edge) state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start_edge) state_d = S_RUN;
        end
        S_DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // prev regs reset high so a button held through reset is not a press
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      presc_q      <= '0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      start_prev_q <= start_prev_d;
      pause_prev_q <= pause_prev_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign tmr.count   = count_q;
  assign tmr.running = running_q;
  assign tmr.done    = done_q;

endmodule

// File: doc/eight_bit_down_timer.md
Name: eight_bit_down_timer

Overview:
- 8-bit countdown timer. It is the down-counting counterpart of the board's free-running up counter.
- Loads a start value from switches, then counts down one step per prescaled tick (1 s at 100 MHz by default).
- Supports start, pause and resume, and raises a sticky done flag at zero.
- Drives the LED bank and status LEDs. Buttons arrive already synchronised to clk.

Parameters:
- TICK_DIV, 100000000: clk cycles per count tick (>= 2). The tick period is exactly TICK_DIV cycles.
- WIDTH, 8: width of the count, the load value and the output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_btn  input  1  asynchronous, active-low reset (0 = reset). Assertion takes effect immediately, independent of clk.
- load_value  input  WIDTH  start value, sampled while preset_btn=1.
- preset_btn  input  1  level load. While high: count<=load_value, state IDLE.
- start_btn  input  1  rising edge starts from IDLE or resumes from PAUSED.
- pause_btn  input  1  rising edge pauses from RUN.
- count  output  WIDTH  current count (registered).
- running  output  1  1 when state is RUN (registered).
- done  output  1  1 when state is DONE (registered, sticky).

Behaviour:
- Reset (reset_btn=0), asynchronous:
  - state=IDLE, count=0, prescaler=0, running=0, done=0.
  - start_prev=1 and pause_prev=1, so a button held through reset release is not a press.
- Edge detect:
  - start_edge = start_btn & ~start_prev; pause_edge likewise.
  - The prev registers update every cycle in every state.
- Prescaler:
  - Width clog2(TICK_DIV); counts 0..TICK_DIV-1 and wraps to 0.
  - Advances only in RUN; holds its value in PAUSED; cleared on entry to RUN from IDLE and by preset.
  - tick = (state==RUN) && (prescaler==TICK_DIV-1).
- Priority per cycle: preset_btn > tick > start/pause edges.
- States:
  - IDLE:
    - start_edge with count!=0 -> RUN (prescaler=0).
    - start_edge with count==0 -> DONE next cycle.
    - pause_edge is ignored.
  - RUN:
    - On tick, count<=count-1. If count==1 at the tick, count becomes 0 and the next state is DONE.
    - pause_edge without tick -> PAUSED.
    - tick and pause_edge in the same cycle: the decrement is applied, then PAUSED (or DONE if count reached 0; DONE wins).
    - start_edge is ignored.
  - PAUSED:
    - start_edge -> RUN, resuming from the held prescaler value. The remaining time of the current tick is preserved.
    - pause_edge is ignored.
  - DONE:
    - count holds 0; start and pause edges are ignored.
    - Exits only via preset_btn or reset.
- preset_btn=1 in any state:
  - Next cycle: count=load_value, state=IDLE, prescaler=0, done=0, running=0.
  - While held, count tracks load_value every cycle and edges are ignored. The edge detectors still update.
- count never wraps below 0: no decrement occurs when count==0.
- The decrement is modulo 2^WIDTH only in form; the guard above prevents underflow.
- Latency:
  - running/done change 1 cycle after the causing edge or tick.
  - count changes on the same clock edge as the tick.
- Asynchronous reset mid-run aborts immediately. Release gives IDLE with count=0.

Test Plan (TICK_DIV=4):
1. Reset then preset: reset_btn=0 mid-cycle -> count=0, running=0, done=0 without a clk edge. Release, then preset_btn=1 with load_value=3 for 1 cycle -> count=3, IDLE.
2. Full countdown: load 3, pulse start_btn -> running=1. count goes 3->2->1->0 at 4-cycle intervals. done=1 and running=0 on the cycle count hits 0. done stays 1 for 20 further cycles, including start pulses.
3. Pause/resume: load 5, start, pause after 2 prescaler cycles -> running=0, count=5 holds for 10 cycles. Start -> the first decrement occurs 2 cycles later (remaining tick time kept).
4. Simultaneous events: pause_edge coincident with tick at count=2 -> count=1, state PAUSED. Repeat at count=1 -> count=0, done=1, not paused.
5. Zero and held buttons: load 0, start -> done=1 next cycle, no decrement. Hold start_btn high across reset release -> no start detected until it is released and pressed again.
6. Preset override: during RUN at count=7, hold preset_btn with load_value=8'hFF -> count=FF, IDLE, done=0. Start edges are ignored while the preset is held.
